// File: rtl/clk_div_gen.sv
// clk_div_gen: multi-channel clock divider with runtime-programmable ratios,
// one pending configuration slot applied at period boundaries, channel
// realignment via sync_pulse, and a counted downstream reset release.
// Optional build macro CLK_DIV_GATE_EN adds per-channel gate_en inputs that
// park a channel at the end of its current period.
`timescale 1ns/1ps
module clk_div_gen #(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 4,
  parameter int RST_HOLD    = 1024
) (
  input  logic              clk_ref,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_err,
  input  logic              sync_pulse,
`ifdef CLK_DIV_GATE_EN
  input  logic [NUM_CH-1:0] gate_en,
`endif
  output logic [NUM_CH-1:0] div_en,
  output logic [NUM_CH-1:0] div_clk,
  output logic              rst_n_out
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  div_q [NUM_CH];
  logic [CNT_W-1:0]  div_d [NUM_CH];
  logic [NUM_CH-1:0] div_en_q, div_en_d;
  logic [NUM_CH-1:0] div_clk_q, div_clk_d;
  logic [NUM_CH-1:0] gated_q, gated_d;
  logic [NUM_CH-1:0] running, at_last, gate_on;
  logic              pend_q, pend_d;
  logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
  logic [CNT_W-1:0]  pend_div_q, pend_div_d;
  logic              cfg_err_q, cfg_err_d;
  logic              accept, ch_ok;
  logic [HOLD_W-1:0] hold_q;
  logic              rst_n_q;

`ifdef CLK_DIV_GATE_EN
  assign gate_on = gate_en;
`else
  assign gate_on = '1;
`endif

  // A single pending slot: ready exactly when nothing is waiting to apply.
  assign cfg_ready = ~pend_q;
  assign cfg_err   = cfg_err_q;
  assign div_en    = div_en_q;
  assign div_clk   = div_clk_q;
  assign rst_n_out = rst_n_q;

  // Per-channel decode: is the channel dividing, and is this its last count.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      running[i] = div_q[i] >= CNT_W'(2);
      at_last[i] = running[i] && (cnt_q[i] == div_q[i] - CNT_W'(1));
    end
  end

  // Next-state for counters, registered outputs, gating and the config slot.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    accept     = cfg_valid && cfg_ready;
    ch_ok      = int'(cfg_ch) < NUM_CH;
    pend_d     = pend_q;
    pend_ch_d  = pend_ch_q;
    pend_div_d = pend_div_q;
    cfg_err_d  = accept && !ch_ok;
    if (accept && ch_ok) begin
      pend_d     = 1'b1;
      pend_ch_d  = cfg_ch;
      pend_div_d = cfg_div;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      div_d[i]     = div_q[i];
      gated_d[i]   = gated_q[i];
      div_en_d[i]  = (div_q[i] == CNT_W'(1)) || at_last[i];
      div_clk_d[i] = running[i] && (cnt_q[i] < (div_q[i] >> 1));
      cnt_d[i]     = (!running[i] || at_last[i] || sync_pulse) ? '0
                                                              : cnt_q[i] + CNT_W'(1);
      // A parked channel sits at zero with quiet outputs until re-enabled.
      if (gated_q[i]) begin
        div_en_d[i]  = 1'b0;
        div_clk_d[i] = 1'b0;
        cnt_d[i]     = '0;
        gated_d[i]   = !gate_on[i];
      end else if (!gate_on[i] && (!running[i] || at_last[i])) begin
        gated_d[i] = 1'b1;
      end
      // Swap the ratio only where the old period ends, so no runt pulse.
      if (pend_q && (pend_ch_q == CH_W'(i)) &&
          (!running[i] || at_last[i] || sync_pulse || gated_q[i])) begin
        div_d[i] = pend_div_q;
        cnt_d[i] = '0;
        pend_d   = 1'b0;
      end
    end
  end

  // Channel, output and config state; reset restores defaults and drops pending.
  always_ff @(posedge clk_ref) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the ratio and counter arrays are small flop banks whose reset
      // values are visible at the outputs, so they are reset explicitly.
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= CNT_W'(DEFAULT_DIV);
      end
      div_en_q   <= '0;
      div_clk_q  <= '0;
      gated_q    <= '0;
      pend_q     <= 1'b0;
      pend_ch_q  <= '0;
      pend_div_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      div_en_q   <= div_en_d;
      div_clk_q  <= div_clk_d;
      gated_q    <= gated_d;
      pend_q     <= pend_d;
      pend_ch_q  <= pend_ch_d;
      pend_div_q <= pend_div_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // Downstream reset release: count RST_HOLD cycles, then hold rst_n_out high.
  always_ff @(posedge clk_ref) begin
    if (reset) begin
      hold_q  <= '0;
      rst_n_q <= 1'b0;
    end else if (!rst_n_q) begin
      if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
        rst_n_q <= 1'b1;
      end else begin
        hold_q <= hold_q + HOLD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed testbench for clk_div_gen with NUM_CH = 3 so that cfg_ch = 3 is
// an out-of-range channel. Inputs change 1 ns after a rising edge and
// outputs are sampled at that same point.
`timescale 1ns/1ps
module tb_clk_div_gen;

  localparam int NUM_CH = 3;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 16;

  logic              clk_ref    = 1'b0;
  logic              reset      = 1'b1;
  logic              cfg_valid  = 1'b0;
  logic [CH_W-1:0]   cfg_ch     = '0;
  logic [CNT_W-1:0]  cfg_div    = '0;
  logic              sync_pulse = 1'b0;
  logic              cfg_ready, cfg_err, rst_n_out;
  logic [NUM_CH-1:0] div_en, div_clk;
`ifdef CLK_DIV_GATE_EN
  logic [NUM_CH-1:0] gate_en = '1;
`endif

  int vectors     = 0;
  int miscompares = 0;

  clk_div_gen #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W), .DEFAULT_DIV(4), .RST_HOLD(1024)
  ) dut (
    .clk_ref(clk_ref),
    .reset(reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_err(cfg_err),
    .sync_pulse(sync_pulse),
`ifdef CLK_DIV_GATE_EN
    .gate_en(gate_en),
`endif
    .div_en(div_en),
    .div_clk(div_clk),
    .rst_n_out(rst_n_out)
  );

  always #5 clk_ref = ~clk_ref;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk_ref);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one config request for one edge.
  task automatic send_cfg(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] dv);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = dv;
    step();
    cfg_valid = 1'b0;
  endtask

  // Bounded wait for cfg_ready; an expired bound shows as a miscompare.
  task automatic wait_ready(input string tag);
    int n = 0;
    while (cfg_ready !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    check(tag, 32'(cfg_ready), 32'd1);
  endtask

  // Drop reset, check the divide-by-4 pattern on every channel and the
  // 1024-cycle release of rst_n_out. Edge k is the k-th edge with reset low.
  task automatic release_defaults(input string tag);
    logic [7:0] exp_clk = 8'b0011_0011;
    logic [7:0] exp_en  = 8'b1000_1000;
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check({tag, " div_clk"}, 32'(div_clk), 32'({NUM_CH{exp_clk[k-1]}}));
      check({tag, " div_en"}, 32'(div_en), 32'({NUM_CH{exp_en[k-1]}}));
    end
    repeat (1023 - 8) step();
    check({tag, " rst_n_out at 1023"}, 32'(rst_n_out), 32'd0);
    step();
    check({tag, " rst_n_out at 1024"}, 32'(rst_n_out), 32'd1);
  endtask

  logic [9:0] c1_clk = 10'b00011_00011;
  logic [9:0] c1_en  = 10'b10000_10000;
  logic [2:0] s_clk [6] = '{3'b111, 3'b110, 3'b100, 3'b001, 3'b010, 3'b010};
  logic [2:0] s_en  [6] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b000, 3'b101};

  initial begin
    // Reset state while reset is held.
    step();
    step();
    check("rst div_en", 32'(div_en), 32'd0);
    check("rst div_clk", 32'(div_clk), 32'd0);
    check("rst cfg_err", 32'(cfg_err), 32'd0);
    check("rst cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst rst_n_out", 32'(rst_n_out), 32'd0);

    // Defaults after release; now just after edge 1024, all counters at 0.
    release_defaults("init");

    // ch1 -> 5 mid-period: accepted at edge 1026, applied at edge 1028.
    step();
    send_cfg(2'd1, 16'd5);
    check("div5 ready low", 32'(cfg_ready), 32'd0);
    check("div5 old clk1 a", 32'(div_clk[1]), 32'd1);
    step();
    check("div5 ready still low", 32'(cfg_ready), 32'd0);
    check("div5 old clk1 b", 32'(div_clk[1]), 32'd0);
    step();
    check("div5 ready back", 32'(cfg_ready), 32'd1);
    check("div5 last old tick", 32'(div_en[1]), 32'd1);
    for (int j = 1; j <= 10; j++) begin
      step();
      check("div5 clk1", 32'(div_clk[1]), 32'(c1_clk[j-1]));
      check("div5 en1", 32'(div_en[1]), 32'(c1_en[j-1]));
    end

    // Out-of-range channel: error pulse only.
    send_cfg(2'd3, 16'd7);
    check("err pulse", 32'(cfg_err), 32'd1);
    check("err ready", 32'(cfg_ready), 32'd1);
    step();
    check("err cleared", 32'(cfg_err), 32'd0);
    check("err ready kept", 32'(cfg_ready), 32'd1);
    check("err ch1 untouched", 32'(div_clk[1]), 32'd1);

    // ch2 -> 0 (waits for ch2 boundary at edge 1044), then -> 1.
    send_cfg(2'd2, 16'd0);
    check("stop ready low", 32'(cfg_ready), 32'd0);
    step();
    step();
    step();
    check("stop ready back", 32'(cfg_ready), 32'd1);
    check("stop final tick", 32'(div_en[2]), 32'd1);
    check("stop final clk", 32'(div_clk[2]), 32'd0);
    step();
    check("stopped en2 a", 32'(div_en[2]), 32'd0);
    check("stopped clk2 a", 32'(div_clk[2]), 32'd0);
    step();
    check("stopped en2 b", 32'(div_en[2]), 32'd0);
    check("stopped clk2 b", 32'(div_clk[2]), 32'd0);
    send_cfg(2'd2, 16'd1);
    check("div1 ready low", 32'(cfg_ready), 32'd0);
    step();
    check("div1 applied next cycle", 32'(cfg_ready), 32'd1);
    check("div1 en2 still old", 32'(div_en[2]), 32'd0);
    for (int j = 0; j < 3; j++) begin
      step();
      check("div1 en2", 32'(div_en[2]), 32'd1);
      check("div1 clk2", 32'(div_clk[2]), 32'd0);
    end

    // Ratios 3,4,6 on ch0..ch2; ch1 update is pending when sync arrives.
    send_cfg(2'd2, 16'd6);
    wait_ready("prog ch2 ready");
    send_cfg(2'd0, 16'd3);
    wait_ready("prog ch0 ready");
    send_cfg(2'd1, 16'd4);
    check("sync pending", 32'(cfg_ready), 32'd0);
    sync_pulse = 1'b1;
    step();
    sync_pulse = 1'b0;
    check("sync applies pending", 32'(cfg_ready), 32'd1);
    for (int j = 1; j <= 6; j++) begin
      step();
      check("sync clk", 32'(div_clk), 32'(s_clk[j-1]));
      check("sync en", 32'(div_en), 32'(s_en[j-1]));
    end

    // Sync coincident with a ch0 boundary (ch0 cnt = 2).
    step();
    step();
    sync_pulse = 1'b1;
    step();
    sync_pulse = 1'b0;
    check("sync@bnd clk", 32'(div_clk), 32'b110);
    check("sync@bnd en", 32'(div_en), 32'b001);
    for (int j = 1; j <= 3; j++) begin
      step();
      check("resync clk", 32'(div_clk), 32'(s_clk[j-1]));
      check("resync en", 32'(div_en), 32'(s_en[j-1]));
    end

    // Reset while a ch0 update is pending and rst_n_out is high.
    send_cfg(2'd0, 16'd7);
    check("pre-reset pending", 32'(cfg_ready), 32'd0);
    check("pre-reset rst_n_out", 32'(rst_n_out), 32'd1);
    reset = 1'b1;
    step();
    check("mid rst rst_n_out", 32'(rst_n_out), 32'd0);
    check("mid rst ready", 32'(cfg_ready), 32'd1);
    check("mid rst div_en", 32'(div_en), 32'd0);
    check("mid rst div_clk", 32'(div_clk), 32'd0);
    release_defaults("rerst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
